// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with result capture, operand query and commit
//
// Purpose:
//   Allocates one entry per issued instruction at the tail, captures results
//   broadcast by the reservation station (rs*) and load/store buffer (lsb*),
//   answers two combinational operand queries, and retires the head entry in
//   order. A mispredicted branch at the head flushes the whole buffer.
//
// Ports:
//   clockIn, resetIn (sync, active high), readyIn (global enable / hold)
//   issue*           : allocate an entry at tailIndex
//   full, tailIndex  : allocation status
//   query1*/query2*  : operand lookups with same-cycle update bypass
//   rsUpdate*/lsb*   : result broadcasts
//   regCommit*       : register write pulse
//   storeCommit*     : store release pulse
//   clear, clearPc   : mispredict flush pulse and redirect PC

module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueDest,
    input  logic [31:0]          issueVal,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic                 full,
    output logic [ROB_WIDTH-1:0] tailIndex,
    input  logic [ROB_WIDTH-1:0] query1Index,
    output logic                 query1Ready,
    output logic [31:0]          query1Val,
    input  logic [ROB_WIDTH-1:0] query2Index,
    output logic                 query2Ready,
    output logic [31:0]          query2Val,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsUpdateVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbUpdateVal,
    output logic                 regCommit,
    output logic [4:0]           regCommitDest,
    output logic [31:0]          regCommitVal,
    output logic [ROB_WIDTH-1:0] regCommitRobIndex,
    output logic                 storeCommit,
    output logic [ROB_WIDTH-1:0] storeCommitRobIndex,
    output logic                 clear,
    output logic [31:0]          clearPc
);

    localparam int DEPTH = 1 << ROB_WIDTH;

    localparam logic [1:0] T_REG       = 2'b00;
    localparam logic [1:0] T_STORE     = 2'b01;
    localparam logic [1:0] T_BRANCH    = 2'b10;
    localparam logic [1:0] T_REG_READY = 2'b11;

    localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
    localparam logic [ROB_WIDTH:0]   CNT_MAX  = (ROB_WIDTH+1)'(DEPTH);
    localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(DEPTH - 1);
    localparam logic [ROB_WIDTH-1:0] IDX_ONE  = ROB_WIDTH'(1);

    // entry storage
    logic [1:0]  type_q  [DEPTH];
    logic [1:0]  type_d  [DEPTH];
    logic [4:0]  dest_q  [DEPTH];
    logic [4:0]  dest_d  [DEPTH];
    logic [31:0] value_q [DEPTH];
    logic [31:0] value_d [DEPTH];
    logic        ready_q [DEPTH];
    logic        ready_d [DEPTH];
    logic        pred_q  [DEPTH];
    logic        pred_d  [DEPTH];
    logic [31:0] alt_pc_q[DEPTH];
    logic [31:0] alt_pc_d[DEPTH];

    // pointers
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // registered outputs
    logic                 reg_commit_q, reg_commit_d;
    logic [4:0]           reg_commit_dest_q, reg_commit_dest_d;
    logic [31:0]          reg_commit_val_q, reg_commit_val_d;
    logic [ROB_WIDTH-1:0] reg_commit_idx_q, reg_commit_idx_d;
    logic                 store_commit_q, store_commit_d;
    logic [ROB_WIDTH-1:0] store_commit_idx_q, store_commit_idx_d;
    logic                 clear_q, clear_d;
    logic [31:0]          clear_pc_q, clear_pc_d;

    logic commit_fire;
    logic flush;
    logic issue_ok;
    logic rs_ok;
    logic lsb_ok;

    always_comb begin
        // Commit looks only at registered ready, so a result captured this
        // cycle retires no earlier than next cycle.
        commit_fire = readyIn && (count_q != '0) && ready_q[head_q];
        flush       = commit_fire && (type_q[head_q] == T_BRANCH)
                      && (value_q[head_q][0] != pred_q[head_q]);
        // The cycle after a flush (clear_q high) and the flush cycle itself
        // discard all new work.
        issue_ok = readyIn && issueValid && !clear_q && !flush && (count_q != CNT_MAX);
        rs_ok    = readyIn && rsUpdate   && !clear_q && !flush;
        lsb_ok   = readyIn && lsbUpdate  && !clear_q && !flush;
    end

    always_comb begin
        type_d   = type_q;
        dest_d   = dest_q;
        value_d  = value_q;
        ready_d  = ready_q;
        pred_d   = pred_q;
        alt_pc_d = alt_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        // Pulses drop each enabled cycle; while readyIn is low they hold.
        reg_commit_d       = readyIn ? 1'b0 : reg_commit_q;
        reg_commit_dest_d  = reg_commit_dest_q;
        reg_commit_val_d   = reg_commit_val_q;
        reg_commit_idx_d   = reg_commit_idx_q;
        store_commit_d     = readyIn ? 1'b0 : store_commit_q;
        store_commit_idx_d = store_commit_idx_q;
        clear_d            = readyIn ? 1'b0 : clear_q;
        clear_pc_d         = clear_pc_q;

        if (issue_ok) begin
            type_d[tail_q]   = issueType;
            dest_d[tail_q]   = issueDest;
            value_d[tail_q]  = issueVal;
            ready_d[tail_q]  = (issueType == T_STORE) || (issueType == T_REG_READY);
            pred_d[tail_q]   = issuePredTaken;
            alt_pc_d[tail_q] = issueAltPc;
            tail_d           = tail_q + IDX_ONE;
        end

        // lsb is applied last so it wins a same-index collision
        if (rs_ok) begin
            value_d[rsRobIndex] = rsUpdateVal;
            ready_d[rsRobIndex] = 1'b1;
        end
        if (lsb_ok) begin
            value_d[lsbRobIndex] = lsbUpdateVal;
            ready_d[lsbRobIndex] = 1'b1;
        end

        if (commit_fire) begin
            head_d = head_q + IDX_ONE;
            case (type_q[head_q])
                T_REG, T_REG_READY: begin
                    reg_commit_d      = 1'b1;
                    reg_commit_dest_d = dest_q[head_q];
                    reg_commit_val_d  = value_q[head_q];
                    reg_commit_idx_d  = head_q;
                end
                T_STORE: begin
                    store_commit_d     = 1'b1;
                    store_commit_idx_d = head_q;
                end
                default: begin
                    if (flush) begin
                        clear_d    = 1'b1;
                        clear_pc_d = alt_pc_q[head_q];
                    end
                end
            endcase
        end

        if (issue_ok && !commit_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (!issue_ok && commit_fire) begin
            count_d = count_q - CNT_ONE;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ready_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= '0;
                dest_q[i]   <= '0;
                value_q[i]  <= '0;
                ready_q[i]  <= 1'b0;
                pred_q[i]   <= 1'b0;
                alt_pc_q[i] <= '0;
            end
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            reg_commit_q       <= 1'b0;
            reg_commit_dest_q  <= '0;
            reg_commit_val_q   <= '0;
            reg_commit_idx_q   <= '0;
            store_commit_q     <= 1'b0;
            store_commit_idx_q <= '0;
            clear_q            <= 1'b0;
            clear_pc_q         <= '0;
        end else begin
            type_q             <= type_d;
            dest_q             <= dest_d;
            value_q            <= value_d;
            ready_q            <= ready_d;
            pred_q             <= pred_d;
            alt_pc_q           <= alt_pc_d;
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            reg_commit_q       <= reg_commit_d;
            reg_commit_dest_q  <= reg_commit_dest_d;
            reg_commit_val_q   <= reg_commit_val_d;
            reg_commit_idx_q   <= reg_commit_idx_d;
            store_commit_q     <= store_commit_d;
            store_commit_idx_q <= store_commit_idx_d;
            clear_q            <= clear_d;
            clear_pc_q         <= clear_pc_d;
        end
    end

    // Operand queries: a broadcast in flight this cycle bypasses storage,
    // with the reservation station taking priority over the lsb.
    always_comb begin
        if (rsUpdate && rsRobIndex == query1Index) begin
            query1Ready = 1'b1;
            query1Val   = rsUpdateVal;
        end else if (lsbUpdate && lsbRobIndex == query1Index) begin
            query1Ready = 1'b1;
            query1Val   = lsbUpdateVal;
        end else begin
            query1Ready = ready_q[query1Index];
            query1Val   = value_q[query1Index];
        end

        if (rsUpdate && rsRobIndex == query2Index) begin
            query2Ready = 1'b1;
            query2Val   = rsUpdateVal;
        end else if (lsbUpdate && lsbRobIndex == query2Index) begin
            query2Ready = 1'b1;
            query2Val   = lsbUpdateVal;
        end else begin
            query2Ready = ready_q[query2Index];
            query2Val   = value_q[query2Index];
        end
    end

    assign full                = (count_q >= CNT_FULL);
    assign tailIndex           = tail_q;
    assign regCommit           = reg_commit_q;
    assign regCommitDest       = reg_commit_dest_q;
    assign regCommitVal        = reg_commit_val_q;
    assign regCommitRobIndex   = reg_commit_idx_q;
    assign storeCommit         = store_commit_q;
    assign storeCommitRobIndex = store_commit_idx_q;
    assign clear               = clear_q;
    assign clearPc             = clear_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard testbench for reorder_buffer
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        resetIn, readyIn, issueValid, issuePredTaken;
    logic [1:0]  issueType;
    logic [4:0]  issueDest;
    logic [31:0] issueVal, issueAltPc;
    logic        full;
    logic [3:0]  tailIndex, query1Index, query2Index, rsRobIndex, lsbRobIndex;
    logic        query1Ready, query2Ready;
    logic [31:0] query1Val, query2Val, rsUpdateVal, lsbUpdateVal;
    logic        rsUpdate, lsbUpdate;
    logic        regCommit, storeCommit, clear;
    logic [4:0]  regCommitDest;
    logic [31:0] regCommitVal, clearPc;
    logic [3:0]  regCommitRobIndex, storeCommitRobIndex;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn),
        .issueValid(issueValid), .issueType(issueType), .issueDest(issueDest),
        .issueVal(issueVal), .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .full(full), .tailIndex(tailIndex),
        .query1Index(query1Index), .query1Ready(query1Ready), .query1Val(query1Val),
        .query2Index(query2Index), .query2Ready(query2Ready), .query2Val(query2Val),
        .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
        .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal),
        .regCommit(regCommit), .regCommitDest(regCommitDest), .regCommitVal(regCommitVal),
        .regCommitRobIndex(regCommitRobIndex),
        .storeCommit(storeCommit), .storeCommitRobIndex(storeCommitRobIndex),
        .clear(clear), .clearPc(clearPc)
    );

    // kind: 0 register write, 1 store release, 2 flush (val = redirect PC)
    typedef struct {
        int          kind;
        logic [4:0]  dest;
        logic [31:0] val;
        logic [3:0]  idx;
    } ev_t;

    ev_t sb[$];
    int  passed = 0;
    int  total  = 0;
    logic rdy_at_edge = 1'b0;

    localparam logic [1:0] T_REG = 2'b00, T_STORE = 2'b01, T_BRANCH = 2'b10, T_REG_READY = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic expect_ev(input int kind, input logic [4:0] dest, input logic [31:0] val,
                             input logic [3:0] idx);
        ev_t e;
        e.kind = kind; e.dest = dest; e.val = val; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issueValid = 0; issueType = 0; issueDest = 0; issueVal = 0;
        issuePredTaken = 0; issueAltPc = 0;
        rsUpdate = 0; rsRobIndex = 0; rsUpdateVal = 0;
        lsbUpdate = 0; lsbRobIndex = 0; lsbUpdateVal = 0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] d, input logic [31:0] v,
                             input logic p, input logic [31:0] pc);
        issueValid = 1; issueType = t; issueDest = d; issueVal = v;
        issuePredTaken = p; issueAltPc = pc;
    endtask

    task automatic do_reset();
        idle_inputs();
        readyIn = 1;
        resetIn = 1;
        step();
        step();
        resetIn = 0;
    endtask

    // pulse outputs only represent a new event if the DUT was enabled at that edge
    always @(posedge clk) rdy_at_edge <= readyIn;

    always @(negedge clk) begin
        if (!resetIn && rdy_at_edge && (regCommit || storeCommit || clear)) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event reg=%0b store=%0b clear=%0b required=none",
                         regCommit, storeCommit, clear);
            end else begin
                ev_t e;
                int  k;
                logic ok;
                e = sb.pop_front();
                k = clear ? 2 : (storeCommit ? 1 : 0);
                ok = (k == e.kind) && ((regCommit + storeCommit + clear) == 1);
                if (ok && k == 0) ok = (regCommitDest == e.dest) && (regCommitVal == e.val)
                                       && (regCommitRobIndex == e.idx);
                if (ok && k == 1) ok = (storeCommitRobIndex == e.idx);
                if (ok && k == 2) ok = (clearPc == e.val);
                if (ok) passed++;
                else $display("FAIL commit_event actual kind=%0d dest=%0d val=0x%0h idx=%0d sidx=%0d pc=0x%0h required kind=%0d dest=%0d val=0x%0h idx=%0d",
                              k, regCommitDest, regCommitVal, regCommitRobIndex,
                              storeCommitRobIndex, clearPc, e.kind, e.dest, e.val, e.idx);
            end
        end
    end

    initial begin
        query1Index = 0; query2Index = 0;
        do_reset();

        // reset state
        check("rst_full", full, 0);
        check("rst_tail", tailIndex, 0);
        check("rst_regcommit", regCommit, 0);
        check("rst_storecommit", storeCommit, 0);
        check("rst_clear", clear, 0);
        check("rst_q1ready", query1Ready, 0);

        // single REG issue, update, commit
        set_issue(T_REG, 5, 0, 0, 0);
        expect_ev(0, 5, 32'h1234, 0);
        step();
        idle_inputs();
        check("t1_tail", tailIndex, 1);
        rsUpdate = 1; rsRobIndex = 0; rsUpdateVal = 32'h1234;
        step();
        idle_inputs();
        check("t1_no_early_commit", regCommit, 0);
        step();
        check("t1_commit_pulse", regCommit, 1);
        step();
        check("t1_pulse_drop", regCommit, 0);
        check("t1_empty_full", full, 0);

        // out-of-order completion, in-order commit
        do_reset();
        set_issue(T_REG, 2, 0, 0, 0); step();
        set_issue(T_REG, 3, 0, 0, 0); step();
        idle_inputs();
        expect_ev(0, 2, 32'hA, 0);
        expect_ev(0, 3, 32'hB, 1);
        rsUpdate = 1; rsRobIndex = 1; rsUpdateVal = 32'hB; step();
        idle_inputs(); step();
        check("t2_idx1_held", regCommit, 0);
        lsbUpdate = 1; lsbRobIndex = 0; lsbUpdateVal = 32'hA; step();
        idle_inputs(); step();
        check("t2_first_idx", regCommitRobIndex, 0);
        step();
        check("t2_second_pulse", regCommit, 1);
        check("t2_second_idx", regCommitRobIndex, 1);
        step();

        // fill to full, 16th accepted, 17th dropped
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_issue(T_REG, 5'(i), 0, 0, 0); step();
        end
        check("t3_full_at_14", full, 0);
        step();
        check("t3_full_at_15", full, 1);
        check("t3_tail_15", tailIndex, 15);
        step();
        check("t3_tail_wrap", tailIndex, 0);
        check("t3_full_at_16", full, 1);
        step();
        check("t3_tail_drop", tailIndex, 0);
        idle_inputs();
        step();

        // mispredicted branch flushes younger entries
        do_reset();
        set_issue(T_BRANCH, 0, 0, 0, 32'h100); step();
        set_issue(T_REG, 7, 0, 0, 0); step();
        set_issue(T_REG, 8, 0, 0, 0); step();
        idle_inputs();
        expect_ev(2, 0, 32'h100, 0);
        rsUpdate = 1; rsRobIndex = 0; rsUpdateVal = 1;
        lsbUpdate = 1; lsbRobIndex = 1; lsbUpdateVal = 32'h77;
        step();
        idle_inputs();
        lsbUpdate = 1; lsbRobIndex = 2; lsbUpdateVal = 32'h88;
        set_issue(T_REG_READY, 9, 5, 0, 0);
        step();
        check("t4_clear", clear, 1);
        check("t4_clearpc", clearPc, 32'h100);
        check("t4_tail_reset", tailIndex, 0);
        idle_inputs();
        set_issue(T_REG_READY, 9, 5, 0, 0);
        rsUpdate = 1; rsRobIndex = 1; rsUpdateVal = 3;
        step();
        idle_inputs();
        check("t4_clear_drop", clear, 0);
        check("t4_issue_ignored", tailIndex, 0);
        query1Index = 1;
        #1;
        check("t4_q1_flushed", query1Ready, 0);
        for (int i = 0; i < 4; i++) step();

        // correctly predicted branch retires silently
        do_reset();
        set_issue(T_BRANCH, 0, 0, 1, 32'h200); step();
        idle_inputs();
        rsUpdate = 1; rsRobIndex = 0; rsUpdateVal = 1; step();
        idle_inputs(); step();
        check("t4b_no_clear", clear, 0);
        set_issue(T_REG_READY, 4, 32'h44, 0, 0);
        expect_ev(0, 4, 32'h44, 1);
        step();
        idle_inputs();
        check("t4b_tail", tailIndex, 2);
        step(); step();

        // query bypass and lsb-wins storage
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(T_REG, 5'(10 + i), 0, 0, 0); step();
        end
        idle_inputs();
        rsUpdate = 1; rsRobIndex = 3; rsUpdateVal = 7; query1Index = 3;
        lsbUpdate = 1; lsbRobIndex = 2; lsbUpdateVal = 32'h55; query2Index = 2;
        #1;
        check("t5_q1_ready_bypass", query1Ready, 1);
        check("t5_q1_val_bypass", query1Val, 7);
        check("t5_q2_ready_bypass", query2Ready, 1);
        check("t5_q2_val_bypass", query2Val, 32'h55);
        step();
        idle_inputs();
        rsUpdate = 1; rsRobIndex = 1; rsUpdateVal = 32'h11;
        lsbUpdate = 1; lsbRobIndex = 1; lsbUpdateVal = 32'h22;
        query1Index = 1;
        #1;
        check("t5_q_rs_priority", query1Val, 32'h11);
        check("t5_q2_stored", query2Val, 32'h55);
        step();
        idle_inputs();
        #1;
        check("t5_lsb_wins_store", query1Val, 32'h22);
        check("t5_stored_ready", query1Ready, 1);
        query1Index = 3;
        #1;
        check("t5_stored_val3", query1Val, 7);
        query1Index = 0;
        #1;
        check("t5_idx0_not_ready", query1Ready, 0);

        // store then REG_READY, with a readyIn hold in between
        do_reset();
        set_issue(T_STORE, 0, 0, 0, 0);
        expect_ev(1, 0, 0, 0);
        step();
        set_issue(T_REG_READY, 1, 9, 0, 0);
        expect_ev(0, 1, 9, 1);
        step();
        idle_inputs();
        check("t6_store_pulse", storeCommit, 1);
        check("t6_store_idx", storeCommitRobIndex, 0);
        readyIn = 0;
        set_issue(T_REG, 6, 0, 0, 0);
        step();
        check("t6_hold_pulse", storeCommit, 1);
        check("t6_hold_no_commit", regCommit, 0);
        check("t6_hold_tail", tailIndex, 2);
        idle_inputs();
        readyIn = 1;
        step();
        check("t6_reg_pulse", regCommit, 1);
        check("t6_store_drop", storeCommit, 0);
        step(); step();

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
